// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO round-robin arbiter.
// Holds the FSM encoding and the pop-to-push pipeline depth.
package fifo_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      HOLD  = 2'd2
   } arb_state_e;

   localparam int DEF_DATA_SIZE = 10;
   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_BURST_LEN = 4;
   localparam int PIPE_DEPTH    = 2;

endpackage

// File: rtl/rr_select.sv
// Rotate-priority pick of the next non-empty requester.
// Search starts at ptr when incl_ptr is set, else just after it.
module rr_select #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   input  logic               incl_ptr,
   output logic [IDX_W-1:0]   next_idx,
   output logic               found
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      next_idx = ptr;
      found    = 1'b0;
      cand     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = IDX_W'((int'(ptr) + k + (incl_ptr ? 0 : 1)) % NUM_REQ);
         if (!found && req[cand]) begin
            found    = 1'b1;
            next_idx = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_arbiter.sv
// Burst-limited round-robin arbiter draining NUM_REQ FIFOs into one.
// Pops are combinational on empty/pause; pushes follow two cycles later.
module fifo_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int DATA_SIZE = DEF_DATA_SIZE,
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int BURST_LEN = DEF_BURST_LEN,
   localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int CNT_W    = $clog2(BURST_LEN + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           fifo_empty_in,
   input  logic [NUM_REQ*DATA_SIZE-1:0] data_in_pop,
   input  logic                         fifo_pause_in,
   input  logic                         arb_enable,
   output logic [NUM_REQ-1:0]           read_out,
   output logic                         write_out,
   output logic [DATA_SIZE-1:0]         data_out_push,
   output logic [IDX_W-1:0]             grant_idx,
   output logic                         arb_busy
);

   arb_state_e             state;
   logic [IDX_W-1:0]       grant_q;
   logic [CNT_W-1:0]       burst_cnt;
   logic [PIPE_DEPTH-1:0]  vld;
   logic [IDX_W-1:0]       pop_idx;
   logic [DATA_SIZE-1:0]   push_q;
   logic [NUM_REQ-1:0]     req;
   logic [IDX_W-1:0]       rr_idx;
   logic                   rr_found;
   logic                   cur_req;
   logic                   pop;
   logic                   last_pop;
   logic                   burst_end;

   assign req       = ~fifo_empty_in;
   assign cur_req   = req[grant_q];
   assign pop       = !reset && (state == GRANT) && arb_enable
                      && !fifo_pause_in && cur_req;
   assign last_pop  = pop && (burst_cnt == CNT_W'(BURST_LEN - 1));
   assign burst_end = last_pop || ((state == GRANT) && !cur_req);

   rr_select #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req      (req),
      .ptr      (grant_q),
      .incl_ptr (state == IDLE),
      .next_idx (rr_idx),
      .found    (rr_found)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         grant_q   <= '0;
         burst_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (arb_enable && !fifo_pause_in && rr_found) begin
                  state     <= GRANT;
                  grant_q   <= rr_idx;
                  burst_cnt <= '0;
               end
            end
            GRANT, HOLD: begin
               if (!arb_enable || !rr_found) begin
                  state     <= IDLE;
                  burst_cnt <= '0;
               end else begin
                  if (state == GRANT && fifo_pause_in)
                     state <= HOLD;
                  else if (state == HOLD && !fifo_pause_in)
                     state <= GRANT;
                  // pointer still advances if a burst ends as pause rises
                  if (burst_end) begin
                     grant_q   <= rr_idx;
                     burst_cnt <= '0;
                  end else if (pop) begin
                     burst_cnt <= burst_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld     <= '0;
         pop_idx <= '0;
         push_q  <= '0;
      end else begin
         vld <= {vld[PIPE_DEPTH-2:0], pop};
         if (pop)
            pop_idx <= grant_q;
         if (vld[0])
            push_q <= data_in_pop[int'(pop_idx)*DATA_SIZE +: DATA_SIZE];
      end
   end

   // outputs forced low for the whole reset cycle, not just after the edge
   assign read_out      = pop ? NUM_REQ'(1) << grant_q : '0;
   assign write_out     = !reset && vld[PIPE_DEPTH-1];
   assign data_out_push = reset ? '0 : push_q;
   assign grant_idx     = reset ? '0 : grant_q;
   assign arb_busy      = !reset && ((state != IDLE) || (|vld));

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter with FIFO models and a push scoreboard.
// Expected pushes are queued at pop time with their due cycle.
module tb_fifo_arbiter;

   localparam int NR = 4;
   localparam int DS = 10;

   typedef struct {
      logic [DS-1:0] data;
      int            due;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic [NR-1:0]     fifo_empty_in;
   logic [NR*DS-1:0]  data_in_pop;
   logic              fifo_pause_in;
   logic              arb_enable;
   logic [NR-1:0]     read_out;
   logic              write_out;
   logic [DS-1:0]     data_out_push;
   logic [1:0]        grant_idx;
   logic              arb_busy;

   logic [DS-1:0]     fq [NR][$];
   exp_t              exp_q [$];
   logic [NR-1:0]     pop_log [$];
   int                pop_cyc [$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int n_wr   = 0;

   logic [NR-1:0] s_rd;
   logic          s_wr;
   logic          s_busy;
   logic [1:0]    s_grant;
   logic [DS-1:0] s_data;

   fifo_arbiter dut (
      .clk           (clk),
      .reset         (reset),
      .fifo_empty_in (fifo_empty_in),
      .data_in_pop   (data_in_pop),
      .fifo_pause_in (fifo_pause_in),
      .arb_enable    (arb_enable),
      .read_out      (read_out),
      .write_out     (write_out),
      .data_out_push (data_out_push),
      .grant_idx     (grant_idx),
      .arb_busy      (arb_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic upd_flags();
      for (int i = 0; i < NR; i++)
         fifo_empty_in[i] = (fq[i].size() == 0);
   endtask

   task automatic load(int idx, int n, int base);
      for (int k = 0; k < n; k++)
         fq[idx].push_back(DS'(base + k));
      upd_flags();
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < NR; i++)
         if (fq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic tick();
      logic [NR-1:0] rd;
      exp_t ent;
      @(negedge clk);
      cyc++;
      s_rd    = read_out;
      s_wr    = write_out;
      s_busy  = arb_busy;
      s_grant = grant_idx;
      s_data  = data_out_push;
      if (write_out === 1'b1) n_wr++;
      if (reset) exp_q.delete();
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         ent = exp_q.pop_front();
         chk("push_strobe", 32'(write_out), 1);
         chk("push_data", 32'(data_out_push), 32'(ent.data));
      end else begin
         chk("no_push", 32'(write_out), 0);
      end
      chk("rd_onehot0", 32'($onehot0(read_out)), 1);
      chk("pop_of_empty", 32'(read_out & fifo_empty_in), 0);
      rd = read_out;
      if (rd != '0) begin
         pop_log.push_back(rd);
         pop_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
         if (rd[i] && fq[i].size() > 0) begin
            ent.data = fq[i].pop_front();
            ent.due  = cyc + 2;
            data_in_pop[i*DS +: DS] = ent.data;
            exp_q.push_back(ent);
         end
      end
      upd_flags();
   endtask

   task automatic drain(int max);
      bit done = 1'b0;
      for (int n = 0; n < max && !done; n++) begin
         tick();
         done = (s_busy == 1'b0) && all_empty() && (exp_q.size() == 0);
      end
      chk("drain_done", 32'(done), 1);
   endtask

   task automatic wait_pops(int mark, int want, int max);
      for (int n = 0; n < max && (pop_log.size() - mark) < want; n++)
         tick();
      chk("pop_wait", pop_log.size() - mark, want);
   endtask

   initial begin
      int mark;
      int w0;
      logic [NR-1:0] e2 [18];
      logic [NR-1:0] e4 [6];

      reset         = 1'b1;
      arb_enable    = 1'b0;
      fifo_pause_in = 1'b0;
      data_in_pop   = '0;
      upd_flags();

      // reset state
      tick();
      tick();
      chk("rst_read", 32'(s_rd), 0);
      chk("rst_write", 32'(s_wr), 0);
      chk("rst_data", 32'(s_data), 0);
      chk("rst_grant", 32'(s_grant), 0);
      chk("rst_busy", 32'(s_busy), 0);
      reset = 1'b0;
      tick();
      chk("idle_busy", 32'(s_busy), 0);
      chk("idle_read", 32'(s_rd), 0);

      // single requester, three words
      load(0, 3, 1);
      arb_enable = 1'b1;
      mark = pop_log.size();
      w0   = n_wr;
      drain(40);
      chk("t1_pops", pop_log.size() - mark, 3);
      for (int j = 0; j < 3; j++)
         chk("t1_idx", 32'(pop_log[mark+j]), 32'h1);
      chk("t1_contig", pop_cyc[mark+2] - pop_cyc[mark], 2);
      chk("t1_writes", n_wr - w0, 3);

      // all four requesters, six words each
      for (int i = 0; i < NR; i++)
         load(i, 6, i*64 + 16);
      for (int j = 0; j < 18; j++)
         e2[j] = 4'b0001 << ((j < 16) ? j/4 : 0);
      mark = pop_log.size();
      w0   = n_wr;
      drain(200);
      chk("t2_pops", pop_log.size() - mark, 24);
      for (int j = 0; j < 18; j++)
         chk("t2_order", 32'(pop_log[mark+j]), 32'(e2[j]));
      chk("t2_contig", pop_cyc[mark+17] - pop_cyc[mark], 17);
      chk("t2_writes", n_wr - w0, 24);
      chk("t2_grant", 32'(s_grant), 3);

      // wrap-around from grant 3 to FIFO1
      load(1, 1, 'h3A0);
      mark = pop_log.size();
      drain(30);
      chk("t3_pops", pop_log.size() - mark, 1);
      chk("t3_idx", 32'(pop_log[mark]), 32'h2);
      chk("t3_grant", 32'(s_grant), 1);

      // pause after second pop of a burst
      load(2, 6, 'h200);
      load(3, 2, 'h300);
      mark = pop_log.size();
      wait_pops(mark, 2, 20);
      chk("t4_first", 32'(pop_log[mark]), 32'h4);
      fifo_pause_in = 1'b1;
      w0 = n_wr;
      for (int j = 0; j < 5; j++) begin
         tick();
         chk("t4_no_pop", 32'(s_rd), 0);
         chk("t4_busy", 32'(s_busy), 1);
      end
      chk("t4_trail", n_wr - w0, 2);
      fifo_pause_in = 1'b0;
      mark = pop_log.size();
      e4 = '{4'h4, 4'h4, 4'h8, 4'h8, 4'h4, 4'h4};
      drain(100);
      chk("t4_pops", pop_log.size() - mark, 6);
      for (int j = 0; j < 6; j++)
         chk("t4_order", 32'(pop_log[mark+j]), 32'(e4[j]));

      // enable dropped mid-burst
      load(3, 6, 'h180);
      mark = pop_log.size();
      w0   = n_wr;
      wait_pops(mark, 2, 20);
      chk("t5_idx", 32'(pop_log[mark]), 32'h8);
      arb_enable = 1'b0;
      tick();
      chk("t5_stop", 32'(s_rd), 0);
      chk("t5_busy0", 32'(s_busy), 1);
      tick();
      chk("t5_busy1", 32'(s_busy), 1);
      tick();
      chk("t5_busy2", 32'(s_busy), 0);
      tick();
      chk("t5_pops", pop_log.size() - mark, 2);
      chk("t5_writes", n_wr - w0, 2);

      // reset one cycle after a pop
      arb_enable = 1'b1;
      mark = pop_log.size();
      wait_pops(mark, 1, 20);
      reset = 1'b1;
      w0 = n_wr;
      tick();
      chk("t6_rst_read", 32'(s_rd), 0);
      chk("t6_rst_write", 32'(s_wr), 0);
      chk("t6_rst_data", 32'(s_data), 0);
      chk("t6_rst_grant", 32'(s_grant), 0);
      chk("t6_rst_busy", 32'(s_busy), 0);
      reset = 1'b0;
      load(1, 2, 'h2C0);
      tick();
      chk("t6_post_write", 32'(s_wr), 0);
      chk("t6_post_grant", 32'(s_grant), 0);
      chk("t6_post_busy", 32'(s_busy), 0);
      chk("t6_no_push", n_wr - w0, 0);
      mark = pop_log.size();
      drain(100);
      chk("t6_pops", pop_log.size() - mark, 5);
      chk("t6_first", 32'(pop_log[mark]), 32'h2);

      chk("sb_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_arbiter.md
FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 Parameter DATA_SIZE, default 10, width of one FIFO word.
REQ-002 Parameter NUM_REQ, default 4, number of requesting input FIFOs.
REQ-003 Parameter BURST_LEN, default 4, maximum consecutive pops granted to one requester.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 fifo_empty_in  input  NUM_REQ  per-requester empty flag; bit i high means FIFO i is empty.
REQ-007 data_in_pop  input  NUM_REQ*DATA_SIZE  concatenated pop data; slice i is FIFO i output, valid one cycle after read_out[i].
REQ-008 fifo_pause_in  input  1  downstream almost-full; high blocks new pops.
REQ-009 arb_enable  input  1  high permits arbitration; low drains in-flight data only.
REQ-010 read_out  output  NUM_REQ  one-hot-or-zero pop strobe to input FIFOs.
REQ-011 write_out  output  1  push strobe to downstream FIFO.
REQ-012 data_out_push  output  DATA_SIZE  word pushed downstream, valid when write_out high.
REQ-013 grant_idx  output  clog2(NUM_REQ)  index of current/last granted requester.
REQ-014 arb_busy  output  1  high when state is not IDLE or any pop is in flight.

Function
REQ-015 FSM states SHALL be IDLE, GRANT, HOLD; encoding from package.
REQ-016 IDLE -> GRANT when arb_enable high, fifo_pause_in low and any fifo_empty_in bit low.
REQ-017 GRANT: read_out[grant_idx] high each cycle the granted FIFO is non-empty, arb_enable high and fifo_pause_in low; at most one read_out bit high per cycle.
REQ-018 Burst counter increments per pop; on reaching BURST_LEN or granted FIFO empty, next-cycle grant moves round-robin to first non-empty requester after grant_idx (wrap NUM_REQ-1 -> 0), counter cleared.
REQ-019 Regrant SHALL be back-to-back: a pop to the new requester may issue in the cycle immediately after the last pop of the previous one.
REQ-020 If the only non-empty requester is grant_idx at burst end, it is regranted with counter cleared.
REQ-021 GRANT -> HOLD when fifo_pause_in rises; HOLD -> GRANT when it falls, keeping grant_idx and burst count.
REQ-022 GRANT/HOLD -> IDLE when all requesters empty or arb_enable low; grant_idx retains value.
REQ-023 Pop-to-push latency SHALL be exactly 2 cycles: read_out[i] at cycle N, data_in_pop slice i registered at N+1, write_out high with that word at N+2.
REQ-024 In-flight words (up to 2) SHALL always be pushed regardless of pause or enable; downstream almost-full threshold must leave room for 2.
REQ-025 Simultaneous pause rise and burst end: no pop issued that cycle; pointer advance still occurs.
REQ-026 Empty flag asserting in the same cycle as a pop: the pop is not issued (fifo_empty_in evaluated combinationally).

Reset
REQ-027 While reset high: state IDLE, read_out 0, write_out 0, data_out_push 0, grant_idx 0, arb_busy 0, burst counter 0, pipeline valid bits 0.
REQ-028 Reset mid-burst SHALL discard in-flight words (no write_out after reset); first grant after reset goes to lowest-index non-empty requester.

Structure
REQ-029 Shared package fifo_arb_pkg SHALL hold state encoding, default DATA_SIZE/NUM_REQ/BURST_LEN, and pipeline depth constant (2).
REQ-030 Sub-module rr_select SHALL compute next grant from request vector and current pointer (combinational rotate-priority).

Verification
REQ-031 Single requester: FIFO0 holds 3 words 0x001..0x003 -> read_out=0001 three cycles, write_out pushes 0x001,0x002,0x003 two cycles later each.
REQ-032 All 4 non-empty, 6 words each -> grant order 0,1,2,3,0 with 4 pops per burst, no idle cycles between bursts.
REQ-033 Pause asserted after 2nd pop of burst -> no further read_out, exactly 2 trailing write_out pulses, resume continues same requester with 2 remaining pops.
REQ-034 grant_idx=3, only FIFO1 non-empty -> next grant 1 (wrap-around).
REQ-035 reset pulsed one cycle after a pop -> no write_out for that word, all outputs 0 next cycle.
REQ-036 arb_enable dropped mid-burst -> pops stop immediately, in-flight words pushed, state IDLE, arb_busy low after 2 cycles.
